axi_line_master: RTL and testbench

- AXI4 burst master that turns cache-line refill and writeback requests into single INCR bursts.
- Sits directly upstream of axi_ram and drives its s_axi_* channels. Cache controllers connect to its simple request/response side.
- Fixed one-line-per-transaction engine: one outstanding transaction, no interleaving, no reordering.

---
 rtl/axi_line_master.sv | 216 +++++++++++++++++++++
 tb/tb_axi_line_master.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_line_master.sv
// AXI4 burst master: one cache-line refill or writeback per INCR burst, one outstanding transaction.
// Optional watchdog enabled by defining YSYX_22041752_AXI_TIMEOUT_EN.
module axi_line_master #(
    parameter int          DATA_WD        = 64,
    parameter int          ADDR_WD        = 32,
    parameter int          LINE_BEATS     = 4,
    parameter logic [3:0]  AXI_ID         = 4'd0,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          rd_req_valid,
    output logic                          rd_req_ready,
    input  logic [ADDR_WD-1:0]            rd_req_addr,
    output logic                          rd_resp_valid,
    output logic [DATA_WD*LINE_BEATS-1:0] rd_resp_line,
    output logic                          rd_resp_err,
    input  logic                          wr_req_valid,
    output logic                          wr_req_ready,
    input  logic [ADDR_WD-1:0]            wr_req_addr,
    input  logic [DATA_WD*LINE_BEATS-1:0] wr_req_line,
    output logic                          wr_resp_valid,
    output logic                          wr_resp_err,
    output logic                          awvalid,
    input  logic                          awready,
    output logic [3:0]                    awid,
    output logic [ADDR_WD-1:0]            awaddr,
    output logic [7:0]                    awlen,
    output logic [2:0]                    awsize,
    output logic [1:0]                    awburst,
    output logic                          wvalid,
    input  logic                          wready,
    output logic [DATA_WD-1:0]            wdata,
    output logic [DATA_WD/8-1:0]          wstrb,
    output logic                          wlast,
    input  logic                          bvalid,
    output logic                          bready,
    input  logic [3:0]                    bid,
    input  logic [1:0]                    bresp,
    output logic                          arvalid,
    input  logic                          arready,
    output logic [3:0]                    arid,
    output logic [ADDR_WD-1:0]            araddr,
    output logic [7:0]                    arlen,
    output logic [2:0]                    arsize,
    output logic [1:0]                    arburst,
    input  logic                          rvalid,
    output logic                          rready,
    input  logic [3:0]                    rid,
    input  logic [DATA_WD-1:0]            rdata,
    input  logic [1:0]                    rresp,
    input  logic                          rlast
);
    localparam int LW  = DATA_WD * LINE_BEATS;
    localparam int CW  = $clog2(LINE_BEATS);
    localparam int OFF = $clog2(LW / 8);

    typedef enum logic [2:0] {ST_IDLE, ST_AR, ST_R, ST_AW, ST_W, ST_B, ST_RESP} state_e;

    state_e            state_r, state_nx_s;
    logic [ADDR_WD-1:0] addr_r;
    logic [LW-1:0]     line_r;
    logic [CW-1:0]     cnt_r;
    logic              err_r;
    logic              is_wr_r;
    logic              last_beat_s, rd_hs_s, wr_hs_s, timeout_s, unused_s;

    assign last_beat_s = (cnt_r == CW'(LINE_BEATS - 1));
    assign rd_hs_s     = rd_req_valid & rd_req_ready;
    assign wr_hs_s     = wr_req_valid & wr_req_ready;

    assign awid    = AXI_ID;
    assign arid    = AXI_ID;
    assign awlen   = 8'(LINE_BEATS - 1);
    assign arlen   = 8'(LINE_BEATS - 1);
    assign awsize  = 3'b011;
    assign arsize  = 3'b011;
    assign awburst = 2'b01;
    assign arburst = 2'b01;
    assign wstrb   = {(DATA_WD/8){1'b1}};
    assign awaddr  = addr_r;
    assign araddr  = addr_r;
    assign wdata   = line_r[cnt_r*DATA_WD +: DATA_WD];
    assign rd_resp_line = line_r;
    assign unused_s = ^{rid, bid, rd_req_addr[OFF-1:0], wr_req_addr[OFF-1:0]};

`ifdef YSYX_22041752_AXI_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt_r;
    logic          wait_s, any_hs_s;

    assign wait_s   = (state_r == ST_AR) || (state_r == ST_R) || (state_r == ST_AW) ||
                      (state_r == ST_W)  || (state_r == ST_B);
    assign any_hs_s = (arvalid & arready) | (rvalid & rready) | (awvalid & awready) |
                      (wvalid & wready) | (bvalid & bready);
    assign timeout_s = wait_s && !any_hs_s && (to_cnt_r == TW'(TIMEOUT_CYCLES - 1));

    // Watchdog: restarts on every handshake and on every state change
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            to_cnt_r <= '0;
        end else if (any_hs_s || (state_nx_s != state_r) || !wait_s) begin
            to_cnt_r <= '0;
        end else begin
            to_cnt_r <= to_cnt_r + TW'(1);
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_r <= ST_IDLE;
        else        state_r <= state_nx_s;
    end

    // Next-state logic; completion of R is counted in beats, never from rlast
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (wr_hs_s)      state_nx_s = ST_AW;
                else if (rd_hs_s) state_nx_s = ST_AR;
                else              state_nx_s = ST_IDLE;
            end
            ST_AR:   state_nx_s = (arvalid & arready) ? ST_R : ST_AR;
            ST_R:    state_nx_s = (rvalid & rready & last_beat_s) ? ST_RESP : ST_R;
            ST_AW:   state_nx_s = (awvalid & awready) ? ST_W : ST_AW;
            ST_W:    state_nx_s = (wvalid & wready & last_beat_s) ? ST_B : ST_W;
            ST_B:    state_nx_s = (bvalid & bready) ? ST_RESP : ST_B;
            ST_RESP: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
        if (timeout_s) state_nx_s = ST_RESP;
        else           state_nx_s = state_nx_s;
    end

    // Output decode; ready outputs are held low while reset is asserted
    always_comb begin
        rd_req_ready  = 1'b0;
        wr_req_ready  = 1'b0;
        arvalid       = 1'b0;
        rready        = 1'b0;
        awvalid       = 1'b0;
        wvalid        = 1'b0;
        wlast         = 1'b0;
        bready        = 1'b0;
        rd_resp_valid = 1'b0;
        rd_resp_err   = 1'b0;
        wr_resp_valid = 1'b0;
        wr_resp_err   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                wr_req_ready = reset;
                rd_req_ready = reset & ~wr_req_valid;
            end
            ST_AR:   arvalid = 1'b1;
            ST_R:    rready  = 1'b1;
            ST_AW:   awvalid = 1'b1;
            ST_W: begin
                wvalid = 1'b1;
                wlast  = last_beat_s;
            end
            ST_B:    bready = 1'b1;
            ST_RESP: begin
                rd_resp_valid = ~is_wr_r;
                rd_resp_err   = ~is_wr_r & err_r;
                wr_resp_valid = is_wr_r;
                wr_resp_err   = is_wr_r & err_r;
            end
            default: rd_req_ready = 1'b0;
        endcase
    end

    // Datapath: request latch, beat slots, beat counter and sticky error
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_r  <= '0;
            line_r  <= '0;
            cnt_r   <= '0;
            err_r   <= 1'b0;
            is_wr_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    err_r <= 1'b0;
                    cnt_r <= '0;
                    if (wr_hs_s) begin
                        addr_r  <= {wr_req_addr[ADDR_WD-1:OFF], {OFF{1'b0}}};
                        line_r  <= wr_req_line;
                        is_wr_r <= 1'b1;
                    end else if (rd_hs_s) begin
                        addr_r  <= {rd_req_addr[ADDR_WD-1:OFF], {OFF{1'b0}}};
                        is_wr_r <= 1'b0;
                    end
                end
                ST_R: begin
                    if (rvalid & rready) begin
                        line_r[cnt_r*DATA_WD +: DATA_WD] <= rdata;
                        cnt_r <= cnt_r + CW'(1);
                        if ((rresp != 2'b00) || (rlast != last_beat_s)) err_r <= 1'b1;
                    end
                end
                ST_W: begin
                    if (wvalid & wready) cnt_r <= cnt_r + CW'(1);
                end
                ST_B: begin
                    if (bvalid & bready & (bresp != 2'b00)) err_r <= 1'b1;
                end
                default: cnt_r <= cnt_r;
            endcase
            if (timeout_s) err_r <= 1'b1;
        end
    end
endmodule

// File: tb/tb_axi_line_master.sv
// Self-checking bench for axi_line_master: the bench plays the AXI slave and the cache controller.
module tb_axi_line_master;
    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         rd_req_valid = 1'b0, rd_req_ready;
    logic [31:0]  rd_req_addr = 32'd0;
    logic         rd_resp_valid, rd_resp_err;
    logic [255:0] rd_resp_line;
    logic         wr_req_valid = 1'b0, wr_req_ready;
    logic [31:0]  wr_req_addr = 32'd0;
    logic [255:0] wr_req_line = 256'd0;
    logic         wr_resp_valid, wr_resp_err;
    logic         awvalid, awready = 1'b0;
    logic [3:0]   awid, arid;
    logic [31:0]  awaddr, araddr;
    logic [7:0]   awlen, arlen;
    logic [2:0]   awsize, arsize;
    logic [1:0]   awburst, arburst;
    logic         wvalid, wready = 1'b0, wlast;
    logic [63:0]  wdata;
    logic [7:0]   wstrb;
    logic         bvalid = 1'b0, bready;
    logic [3:0]   bid = 4'd0, rid = 4'd0;
    logic [1:0]   bresp = 2'd0, rresp = 2'd0;
    logic         arvalid, arready = 1'b0;
    logic         rvalid = 1'b0, rready, rlast = 1'b0;
    logic [63:0]  rdata = 64'd0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] r_beats [4];
    logic [1:0]  r_resps [4];
    logic        r_lasts [4];
    logic [63:0] w_seen  [4];
    logic        wl_seen [4];

    axi_line_master #(.TIMEOUT_CYCLES(16)) dut (
        .clock(clock), .reset(reset),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
        .rd_resp_valid(rd_resp_valid), .rd_resp_line(rd_resp_line), .rd_resp_err(rd_resp_err),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_addr(wr_req_addr),
        .wr_req_line(wr_req_line), .wr_resp_valid(wr_resp_valid), .wr_resp_err(wr_resp_err),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst), .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .wstrb(wstrb), .wlast(wlast), .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .rvalid(rvalid), .rready(rready), .rid(rid),
        .rdata(rdata), .rresp(rresp), .rlast(rlast)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference model: a line is 32 bytes, beat k of the line is bits [64k+63:64k]
    function automatic logic [31:0] exp_align(input logic [31:0] a);
        return a & 32'hFFFF_FFE0;
    endfunction

    function automatic logic [255:0] exp_line();
        logic [255:0] l = 256'd0;
        for (int k = 0; k < 4; k++) l[k*64 +: 64] = r_beats[k];
        return l;
    endfunction

    function automatic logic exp_rd_err();
        logic e = 1'b0;
        for (int k = 0; k < 4; k++)
            if (r_resps[k] != 2'b00 || r_lasts[k] != (k == 3)) e = 1'b1;
        return e;
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic set_good_read();
        for (int k = 0; k < 4; k++) begin
            r_beats[k] = {$urandom, $urandom};
            r_resps[k] = 2'b00;
            r_lasts[k] = (k == 3);
        end
    endtask

    // Drives one refill as slave; o_proto counts handshake/timing rule breaks
    task automatic do_read(input logic [31:0] addr, input int ar_delay, input int gap_pct,
                           output logic [31:0] o_araddr, output logic [255:0] o_line,
                           output logic o_err, output int o_proto);
        int k;
        int budget;
        o_proto  = 0;
        o_araddr = 32'd0;
        rd_req_addr  = addr;
        rd_req_valid = 1'b1;
        #1;
        if (rd_req_ready !== 1'b1) o_proto++;
        tick();
        rd_req_valid = 1'b0;
        rd_req_addr  = $urandom;
        for (int d = 0; d <= ar_delay; d++) begin
            if (arvalid !== 1'b1 || arlen !== 8'd3 || arsize !== 3'd3 || arburst !== 2'd1 || arid !== 4'd0) o_proto++;
            if (d == 0) o_araddr = araddr;
            else if (araddr !== o_araddr) o_proto++;
            arready = (d == ar_delay);
            tick();
        end
        arready = 1'b0;
        k = 0;
        budget = 0;
        while (k < 4 && budget < 64) begin
            if (rready !== 1'b1 || arvalid !== 1'b0 || rd_resp_valid !== 1'b0) o_proto++;
            rid = 4'($urandom);
            if ($urandom_range(99) < gap_pct) begin
                rvalid = 1'b0;
            end else begin
                rvalid = 1'b1;
                rdata  = r_beats[k];
                rresp  = r_resps[k];
                rlast  = r_lasts[k];
                k++;
            end
            tick();
            budget++;
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
        if (k < 4) o_proto++;
        o_line = rd_resp_line;
        o_err  = rd_resp_err;
        if (rd_resp_valid !== 1'b1 || wr_resp_valid !== 1'b0 || rready !== 1'b0) o_proto++;
        tick();
        if (rd_resp_valid !== 1'b0) o_proto++;
    endtask

    // Drives one writeback as slave with wready toggling every other cycle
    task automatic do_write(input logic [31:0] addr, input logic [255:0] line, input logic [1:0] br,
                            input int aw_delay, input int b_delay,
                            output logic [31:0] o_awaddr, output logic o_err, output int o_proto);
        int k;
        int budget;
        o_proto  = 0;
        o_awaddr = 32'd0;
        wr_req_addr  = addr;
        wr_req_line  = line;
        wr_req_valid = 1'b1;
        #1;
        if (wr_req_ready !== 1'b1) o_proto++;
        tick();
        wr_req_valid = 1'b0;
        wr_req_line  = rand_line();
        for (int d = 0; d <= aw_delay; d++) begin
            if (awvalid !== 1'b1 || wvalid !== 1'b0 || arvalid !== 1'b0 || awlen !== 8'd3 ||
                awsize !== 3'd3 || awburst !== 2'd1 || awid !== 4'd0) o_proto++;
            if (d == 0) o_awaddr = awaddr;
            else if (awaddr !== o_awaddr) o_proto++;
            awready = (d == aw_delay);
            tick();
        end
        awready = 1'b0;
        k = 0;
        budget = 0;
        while (k < 4 && budget < 64) begin
            if (wvalid !== 1'b1 || awvalid !== 1'b0 || arvalid !== 1'b0 || wstrb !== 8'hFF) o_proto++;
            wready = (budget % 2 == 1);
            if (wready) begin
                w_seen[k]  = wdata;
                wl_seen[k] = wlast;
                k++;
            end else if (wlast !== (k == 3)) begin
                o_proto++;
            end
            tick();
            budget++;
        end
        wready = 1'b0;
        if (k < 4) o_proto++;
        for (int d = 0; d <= b_delay; d++) begin
            if (bready !== 1'b1 || wvalid !== 1'b0 || wr_resp_valid !== 1'b0) o_proto++;
            bvalid = (d == b_delay);
            bresp  = br;
            bid    = 4'($urandom);
            tick();
        end
        bvalid = 1'b0;
        bresp  = 2'b00;
        o_err  = wr_resp_err;
        if (wr_resp_valid !== 1'b1 || rd_resp_valid !== 1'b0 || bready !== 1'b0) o_proto++;
        tick();
        if (wr_resp_valid !== 1'b0) o_proto++;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({rd_req_ready, wr_req_ready, arvalid, rready, awvalid, wvalid, wlast, bready,
             rd_resp_valid, rd_resp_err, wr_resp_valid, wr_resp_err} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 0", {rd_req_ready, wr_req_ready, arvalid, rready,
                     awvalid, wvalid, wlast, bready, rd_resp_valid, rd_resp_err, wr_resp_valid, wr_resp_err});
        end
        n_checks++;
        if ({rd_resp_line, awaddr, araddr, wdata} !== 384'd0) begin
            n_fail++;
            $display("FAIL reset_data: line %h awaddr %h araddr %h wdata %h required 0", rd_resp_line, awaddr, araddr, wdata);
        end
        n_checks++;
        if ({awlen, arlen, awsize, arsize, awburst, arburst, awid, arid, wstrb} !== {8'd3, 8'd3, 3'd3, 3'd3, 2'd1, 2'd1, 4'd0, 4'd0, 8'hFF}) begin
            n_fail++;
            $display("FAIL constants: got %h", {awlen, arlen, awsize, arsize, awburst, arburst, awid, arid, wstrb});
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if ({rd_req_ready, wr_req_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL idle_ready: got %b required 11", {rd_req_ready, wr_req_ready});
        end
    endtask

    task automatic test_refill();
        logic [31:0]  a;
        logic [255:0] l;
        logic         e;
        int           p;
        for (int k = 0; k < 4; k++) begin
            r_beats[k] = 64'((k + 1) * 17);
            r_resps[k] = 2'b00;
            r_lasts[k] = (k == 3);
        end
        do_read(32'h8000_0013, 0, 0, a, l, e, p);
        n_checks++;
        if (a !== 32'h8000_0000) begin n_fail++; $display("FAIL refill_araddr: got %h required 80000000", a); end
        n_checks++;
        if (l !== {64'h44, 64'h33, 64'h22, 64'h11}) begin n_fail++; $display("FAIL refill_line: got %h", l); end
        n_checks++;
        if (e !== 1'b0) begin n_fail++; $display("FAIL refill_err: got %b required 0", e); end
        n_checks++;
        if (p !== 0) begin n_fail++; $display("FAIL refill_protocol: got %0d violations required 0", p); end
    endtask

    task automatic test_writeback();
        logic [255:0] line = rand_line();
        logic [31:0]  a;
        logic         e;
        int           p;
        do_write(32'h1234_5678, line, 2'b00, 2, 1, a, e, p);
        n_checks++;
        if (a !== 32'h1234_5660) begin n_fail++; $display("FAIL wb_awaddr: got %h required 12345660", a); end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (w_seen[k] !== line[k*64 +: 64] || wl_seen[k] !== (k == 3)) begin
                n_fail++;
                $display("FAIL wb_beat%0d: got %h last %b required %h last %b", k, w_seen[k], wl_seen[k], line[k*64 +: 64], (k == 3));
            end
        end
        n_checks++;
        if (e !== 1'b0 || p !== 0) begin n_fail++; $display("FAIL wb_resp: err %b violations %0d required 0/0", e, p); end
    endtask

    task automatic test_priority();
        logic [255:0] line = rand_line();
        logic [31:0]  a;
        logic [255:0] l;
        logic         e;
        int           p;
        set_good_read();
        rd_req_valid = 1'b1;
        rd_req_addr  = 32'h0000_4040;
        wr_req_valid = 1'b1;
        #1;
        n_checks++;
        if ({rd_req_ready, wr_req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL prio_ready: got %b required 01", {rd_req_ready, wr_req_ready});
        end
        do_write(32'h0000_9000, line, 2'b00, 0, 0, a, e, p);
        n_checks++;
        if (a !== 32'h0000_9000 || e !== 1'b0 || p !== 0) begin
            n_fail++;
            $display("FAIL prio_write: awaddr %h err %b violations %0d", a, e, p);
        end
        do_read(32'h0000_4040, 1, 30, a, l, e, p);
        n_checks++;
        if (a !== 32'h0000_4040 || l !== exp_line() || e !== 1'b0 || p !== 0) begin
            n_fail++;
            $display("FAIL prio_read: araddr %h err %b violations %0d line %h", a, e, p, l);
        end
    endtask

    task automatic test_read_errors();
        logic [31:0]  a;
        logic [255:0] l;
        logic         e;
        int           p;
        for (int c = 0; c < 4; c++) begin
            set_good_read();
            if (c == 0) r_resps[1] = 2'b10;
            if (c == 1) r_lasts[2] = 1'b1;
            if (c == 2) r_lasts[3] = 1'b0;
            do_read(32'h2000_0100 + 32'(c * 32), 0, 20, a, l, e, p);
            n_checks++;
            if (e !== exp_rd_err() || l !== exp_line() || p !== 0) begin
                n_fail++;
                $display("FAIL rd_err_case%0d: err %b required %b violations %0d", c, e, exp_rd_err(), p);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0]  a;
        logic [255:0] l;
        logic         e;
        int           p;
        rd_req_valid = 1'b1;
        rd_req_addr  = 32'h0000_0700;
        tick();
        rd_req_valid = 1'b0;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rvalid = 1'b1;
            rdata  = {$urandom, $urandom} | 64'd1;
            tick();
        end
        rvalid = 1'b0;
        reset  = 1'b0;
        #1;
        n_checks++;
        if ({rd_req_ready, wr_req_ready, arvalid, rready, awvalid, wvalid, bready, rd_resp_valid,
             wr_resp_valid, rd_resp_err, wr_resp_err} !== 11'd0 || rd_resp_line !== 256'd0) begin
            n_fail++;
            $display("FAIL mid_reset: ctrl %b line %h required all 0", {rd_req_ready, wr_req_ready, arvalid,
                     rready, awvalid, wvalid, bready, rd_resp_valid, wr_resp_valid, rd_resp_err, wr_resp_err}, rd_resp_line);
        end
        tick();
        reset = 1'b1;
        tick();
        set_good_read();
        do_read(32'h0000_0800, 0, 0, a, l, e, p);
        n_checks++;
        if (a !== 32'h0000_0800 || l !== exp_line() || e !== 1'b0 || p !== 0) begin
            n_fail++;
            $display("FAIL post_reset_read: araddr %h err %b violations %0d", a, e, p);
        end
    endtask

    task automatic test_random();
        logic [31:0]  addr, a;
        logic [255:0] l, line;
        logic [1:0]   br;
        logic         e;
        int           p;
        for (int t = 0; t < 24; t++) begin
            addr = $urandom;
            if ($urandom_range(1) == 1) begin
                line = rand_line();
                br   = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b00;
                do_write(addr, line, br, $urandom_range(3), $urandom_range(3), a, e, p);
                n_checks++;
                if (a !== exp_align(addr) || e !== (br != 2'b00) || p !== 0) begin
                    n_fail++;
                    $display("FAIL rand_wr%0d: awaddr %h/%h err %b/%b violations %0d", t, a, exp_align(addr), e, (br != 2'b00), p);
                end
                for (int k = 0; k < 4; k++) begin
                    n_checks++;
                    if (w_seen[k] !== line[k*64 +: 64] || wl_seen[k] !== (k == 3)) begin
                        n_fail++;
                        $display("FAIL rand_wr%0d_beat%0d: got %h required %h", t, k, w_seen[k], line[k*64 +: 64]);
                    end
                end
            end else begin
                set_good_read();
                for (int k = 0; k < 4; k++) begin
                    if ($urandom_range(9) == 0) r_resps[k] = 2'($urandom_range(3));
                    if ($urandom_range(9) == 0) r_lasts[k] = ~r_lasts[k];
                end
                do_read(addr, $urandom_range(3), 25, a, l, e, p);
                n_checks++;
                if (a !== exp_align(addr) || l !== exp_line() || e !== exp_rd_err() || p !== 0) begin
                    n_fail++;
                    $display("FAIL rand_rd%0d: araddr %h/%h err %b/%b violations %0d", t, a, exp_align(addr), e, exp_rd_err(), p);
                end
            end
        end
    endtask

`ifdef YSYX_22041752_AXI_TIMEOUT_EN
    task automatic test_timeout();
        int held = 0;
        rd_req_valid = 1'b1;
        rd_req_addr  = 32'h0000_1000;
        tick();
        rd_req_valid = 1'b0;
        while (arvalid === 1'b1 && held < 40) begin
            held++;
            tick();
        end
        n_checks++;
        if (held !== 16) begin n_fail++; $display("FAIL timeout_cycles: got %0d required 16", held); end
        n_checks++;
        if ({rd_resp_valid, rd_resp_err} !== 2'b11) begin
            n_fail++;
            $display("FAIL timeout_resp: got %b required 11", {rd_resp_valid, rd_resp_err});
        end
        tick();
        n_checks++;
        if ({rd_resp_valid, rd_req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL timeout_idle: got %b required 01", {rd_resp_valid, rd_req_ready});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_refill();
        test_writeback();
        test_priority();
        test_read_errors();
        test_reset_mid();
        test_random();
`ifdef YSYX_22041752_AXI_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
